// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM pipeline stage with a two-state (IDLE/ACCESS)
// memory handshake that stalls the upstream pipeline while a load or
// store waits for its acknowledge. Results are written into the MEM/WB
// register.
// Optional feature: define MEM_ACCESS_TIMEOUT_EN to abort an access that
// receives no acknowledge within TIMEOUT_CYCLES cycles. An aborted access
// sets the sticky timeout_o flag.
module mem_access_stage #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        RegWrite_i,
    input  logic        MemtoReg_i,
    input  logic        MemRead_i,
    input  logic        MemWrite_i,
    input  logic [31:0] ALUResult_i,
    input  logic [31:0] MUX2Result_i,
    input  logic [4:0]  RdAddr_i,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i,
    output logic        stall_o,
    output logic        RegWrite_o,
    output logic        MemtoReg_o,
    output logic [31:0] ALUResult_o,
    output logic [31:0] ReadData_o,
    output logic [4:0]  RdAddr_o,
    output logic        timeout_o
);

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] ACCESS = 1'b1;

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 1023) begin : g_bad_timeout
        $error("mem_access_stage: TIMEOUT_CYCLES must be within 2..1023");
    end

    logic [0:0]  state_q, state_d;
    logic        lat_regwrite_q, lat_regwrite_d;
    logic        lat_memtoreg_q, lat_memtoreg_d;
    logic        lat_read_q, lat_read_d;
    logic        lat_we_q, lat_we_d;
    logic [31:0] lat_addr_q, lat_addr_d;
    logic [31:0] lat_wdata_q, lat_wdata_d;
    logic [4:0]  lat_rd_q, lat_rd_d;
    logic        wb_regwrite_q, wb_regwrite_d;
    logic        wb_memtoreg_q, wb_memtoreg_d;
    logic [31:0] wb_alu_q, wb_alu_d;
    logic [31:0] wb_rdata_q, wb_rdata_d;
    logic [4:0]  wb_rd_q, wb_rd_d;
    logic        stall_raw;
    logic        memop;
    logic        timeout_hit;

    assign memop = MemRead_i | MemWrite_i;

`ifdef MEM_ACCESS_TIMEOUT_EN
    localparam logic [9:0] TIMEOUT_LAST = 10'(TIMEOUT_CYCLES - 1);

    logic [9:0] cnt_q, cnt_d;
    logic       timeout_q, timeout_d;

    // Abort when the access has waited its full budget without an ack; ack wins a tie.
    assign timeout_hit = (state_q == ACCESS) && !mem_ack_i && (cnt_q == TIMEOUT_LAST);

    // Count un-acknowledged ACCESS cycles; the count sits at zero in IDLE so every access starts fresh.
    always_comb begin
        cnt_d     = cnt_q;
        timeout_d = timeout_q;
        if (state_q == IDLE) begin
            cnt_d = '0;
        end else if (!mem_ack_i) begin
            cnt_d = cnt_q + 10'd1;
        end
        if (timeout_hit) begin
            timeout_d = 1'b1;
        end
    end

    // Timeout counter and sticky abort flag.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout_o = timeout_q;
`else
    assign timeout_hit = 1'b0;
    assign timeout_o   = 1'b0;
`endif

    // Next-state, request latch and MEM/WB load selection for the handshake FSM.
    always_comb begin
        state_d        = state_q;
        lat_regwrite_d = lat_regwrite_q;
        lat_memtoreg_d = lat_memtoreg_q;
        lat_read_d     = lat_read_q;
        lat_we_d       = lat_we_q;
        lat_addr_d     = lat_addr_q;
        lat_wdata_d    = lat_wdata_q;
        lat_rd_d       = lat_rd_q;
        wb_regwrite_d  = 1'b0;
        wb_memtoreg_d  = 1'b0;
        wb_alu_d       = '0;
        wb_rdata_d     = '0;
        wb_rd_d        = '0;
        stall_raw      = 1'b0;
        case (state_q)
            IDLE: begin
                if (memop) begin
                    stall_raw      = 1'b1;
                    state_d        = ACCESS;
                    lat_regwrite_d = RegWrite_i;
                    lat_memtoreg_d = MemtoReg_i;
                    lat_read_d     = MemRead_i;
                    lat_we_d       = MemWrite_i & ~MemRead_i;
                    lat_addr_d     = ALUResult_i;
                    lat_wdata_d    = MUX2Result_i;
                    lat_rd_d       = RdAddr_i;
                end else begin
                    wb_regwrite_d = RegWrite_i;
                    wb_memtoreg_d = MemtoReg_i;
                    wb_alu_d      = ALUResult_i;
                    wb_rd_d       = RdAddr_i;
                end
            end
            ACCESS: begin
                if (mem_ack_i) begin
                    state_d       = IDLE;
                    wb_regwrite_d = lat_regwrite_q;
                    wb_memtoreg_d = lat_memtoreg_q;
                    wb_alu_d      = lat_addr_q;
                    wb_rd_d       = lat_rd_q;
                    wb_rdata_d    = lat_read_q ? mem_rdata_i : 32'd0;
                end else if (timeout_hit) begin
                    state_d       = IDLE;
                    wb_memtoreg_d = lat_memtoreg_q;
                    wb_alu_d      = lat_addr_q;
                    wb_rd_d       = lat_rd_q;
                end else begin
                    stall_raw = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM state, request latch and MEM/WB pipeline register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q        <= IDLE;
            lat_regwrite_q <= 1'b0;
            lat_memtoreg_q <= 1'b0;
            lat_read_q     <= 1'b0;
            lat_we_q       <= 1'b0;
            lat_addr_q     <= '0;
            lat_wdata_q    <= '0;
            lat_rd_q       <= '0;
            wb_regwrite_q  <= 1'b0;
            wb_memtoreg_q  <= 1'b0;
            wb_alu_q       <= '0;
            wb_rdata_q     <= '0;
            wb_rd_q        <= '0;
        end else begin
            state_q        <= state_d;
            lat_regwrite_q <= lat_regwrite_d;
            lat_memtoreg_q <= lat_memtoreg_d;
            lat_read_q     <= lat_read_d;
            lat_we_q       <= lat_we_d;
            lat_addr_q     <= lat_addr_d;
            lat_wdata_q    <= lat_wdata_d;
            lat_rd_q       <= lat_rd_d;
            wb_regwrite_q  <= wb_regwrite_d;
            wb_memtoreg_q  <= wb_memtoreg_d;
            wb_alu_q       <= wb_alu_d;
            wb_rdata_q     <= wb_rdata_d;
            wb_rd_q        <= wb_rd_d;
        end
    end

    // Stall is forced low while reset is held, even if a memory op is presented.
    assign stall_o     = stall_raw & ~rst_i;
    assign mem_req_o   = (state_q == ACCESS);
    assign mem_we_o    = (state_q == ACCESS) & lat_we_q;
    assign mem_addr_o  = (state_q == ACCESS) ? lat_addr_q : 32'd0;
    assign mem_wdata_o = (state_q == ACCESS) ? lat_wdata_q : 32'd0;

    assign RegWrite_o  = wb_regwrite_q;
    assign MemtoReg_o  = wb_memtoreg_q;
    assign ALUResult_o = wb_alu_q;
    assign ReadData_o  = wb_rdata_q;
    assign RdAddr_o    = wb_rd_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage. Expected values come from the
// transaction being issued (what the stage should do with it), not from the
// RTL's internal state. Build with MEM_ACCESS_TIMEOUT_EN defined to also
// exercise the timeout abort path (TIMEOUT_CYCLES is set to 4 here).
module tb_mem_access_stage;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i;
    logic [31:0] ALUResult_i, MUX2Result_i;
    logic [4:0]  RdAddr_i;
    logic        mem_req_o, mem_we_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;
    logic        stall_o;
    logic        RegWrite_o, MemtoReg_o;
    logic [31:0] ALUResult_o, ReadData_o;
    logic [4:0]  RdAddr_o;
    logic        timeout_o;

    int checks   = 0;
    int failures = 0;

    mem_access_stage #(.TIMEOUT_CYCLES(4)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .RegWrite_i(RegWrite_i), .MemtoReg_i(MemtoReg_i),
        .MemRead_i(MemRead_i), .MemWrite_i(MemWrite_i),
        .ALUResult_i(ALUResult_i), .MUX2Result_i(MUX2Result_i), .RdAddr_i(RdAddr_i),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i),
        .stall_o(stall_o),
        .RegWrite_o(RegWrite_o), .MemtoReg_o(MemtoReg_o),
        .ALUResult_o(ALUResult_o), .ReadData_o(ReadData_o), .RdAddr_o(RdAddr_o),
        .timeout_o(timeout_o)
    );

    // Free-running clock, period 10.
    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic rw, input logic mtr, input logic rd_en, input logic wr_en,
                                 input logic [31:0] alu, input logic [31:0] wdata, input logic [4:0] rd);
        RegWrite_i   = rw;
        MemtoReg_i   = mtr;
        MemRead_i    = rd_en;
        MemWrite_i   = wr_en;
        ALUResult_i  = alu;
        MUX2Result_i = wdata;
        RdAddr_i     = rd;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_req"}, mem_req_o, 0);
        checkOutput({tag, "_we"}, mem_we_o, 0);
        checkOutput({tag, "_addr"}, mem_addr_o, 0);
        checkOutput({tag, "_stall"}, stall_o, 0);
        checkOutput({tag, "_regwrite"}, RegWrite_o, 0);
        checkOutput({tag, "_memtoreg"}, MemtoReg_o, 0);
        checkOutput({tag, "_alu"}, ALUResult_o, 0);
        checkOutput({tag, "_rdata"}, ReadData_o, 0);
        checkOutput({tag, "_rd"}, RdAddr_o, 0);
        checkOutput({tag, "_timeout"}, timeout_o, 0);
    endtask

    // Non-memory op: one cycle, no stall, ReadData forced to 0 (a stray ack is ignored).
    task automatic doAluOp(input logic rw, input logic mtr, input logic [31:0] alu,
                           input logic [4:0] rd, input logic strayAck);
        applyStimulus(rw, mtr, 1'b0, 1'b0, alu, $urandom, rd);
        mem_ack_i   = strayAck;
        mem_rdata_i = $urandom;
        #1;
        checkOutput("alu_stall", stall_o, 0);
        checkOutput("alu_req", mem_req_o, 0);
        @(negedge clk_i);
        mem_ack_i = 1'b0;
        checkOutput("alu_regwrite", RegWrite_o, rw);
        checkOutput("alu_memtoreg", MemtoReg_o, mtr);
        checkOutput("alu_result", ALUResult_o, alu);
        checkOutput("alu_rd", RdAddr_o, rd);
        checkOutput("alu_rdata", ReadData_o, 0);
    endtask

    // Memory op acknowledged after ackDelay waiting ACCESS cycles.
    task automatic doMemOp(input logic rd_en, input logic wr_en, input logic rw, input logic mtr,
                           input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] rd,
                           input int ackDelay, input logic [31:0] rdata);
        logic expWe;
        expWe = wr_en & ~rd_en;
        applyStimulus(rw, mtr, rd_en, wr_en, addr, wdata, rd);
        mem_ack_i = 1'b0;
        #1;
        checkOutput("mem_entry_stall", stall_o, 1);
        checkOutput("mem_entry_req", mem_req_o, 0);
        @(negedge clk_i);
        checkOutput("mem_entry_bubble_rw", RegWrite_o, 0);
        checkOutput("mem_entry_bubble_mtr", MemtoReg_o, 0);
        applyStimulus($urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom);
        for (int c = 0; c <= ackDelay; c++) begin
            mem_ack_i   = (c == ackDelay);
            mem_rdata_i = (c == ackDelay) ? rdata : $urandom;
            #1;
            checkOutput("mem_req", mem_req_o, 1);
            checkOutput("mem_addr", mem_addr_o, addr);
            checkOutput("mem_wdata", mem_wdata_o, wdata);
            checkOutput("mem_we", mem_we_o, expWe);
            checkOutput("mem_stall", stall_o, (c == ackDelay) ? 0 : 1);
            @(negedge clk_i);
            if (c != ackDelay) checkOutput("mem_wait_bubble", RegWrite_o, 0);
        end
        mem_ack_i = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("mem_done_req", mem_req_o, 0);
        checkOutput("mem_done_regwrite", RegWrite_o, rw);
        checkOutput("mem_done_memtoreg", MemtoReg_o, mtr);
        checkOutput("mem_done_alu", ALUResult_o, addr);
        checkOutput("mem_done_rd", RdAddr_o, rd);
        checkOutput("mem_done_rdata", ReadData_o, rd_en ? rdata : 32'd0);
    endtask

`ifdef MEM_ACCESS_TIMEOUT_EN
    // Load with no ack ever: request must last exactly 4 cycles then abort.
    task automatic doTimeoutOp(input logic [31:0] addr, input logic [4:0] rd);
        int reqCycles;
        reqCycles = 0;
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, addr, 32'd0, rd);
        mem_ack_i = 1'b0;
        @(negedge clk_i);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        for (int c = 0; c < 20; c++) begin
            #1;
            if (!mem_req_o) break;
            reqCycles++;
            @(negedge clk_i);
        end
        checkOutput("to_req_cycles", reqCycles, 4);
        checkOutput("to_flag", timeout_o, 1);
        checkOutput("to_regwrite", RegWrite_o, 0);
        checkOutput("to_memtoreg", MemtoReg_o, 1);
        checkOutput("to_alu", ALUResult_o, addr);
        checkOutput("to_rd", RdAddr_o, rd);
        checkOutput("to_rdata", ReadData_o, 0);
        @(negedge clk_i);
        checkOutput("to_sticky", timeout_o, 1);
    endtask
`endif

    initial begin
        rst_i     = 1'b1;
        mem_ack_i = 1'b0;
        mem_rdata_i = '0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk_i);
        #1;
        checkAllZero("reset");
        rst_i = 1'b0;

        // Plain ALU result passes through in one cycle.
        doAluOp(1'b1, 1'b0, 32'h0000_0010, 5'd5, 1'b0);
        // Stray ack in IDLE must not leak read data.
        doAluOp(1'b1, 1'b1, 32'hCAFE_0001, 5'd9, 1'b1);

        // Load acknowledged on the third ACCESS cycle.
        doMemOp(1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0100, 32'h0, 5'd7, 2, 32'hDEAD_BEEF);
        // Store acknowledged immediately: two cycles total.
        doMemOp(1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0200, 32'h1234_5678, 5'd0, 0, 32'hFFFF_FFFF);
        // Read and write together behave as a read.
        doMemOp(1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0300, 32'hAAAA_5555, 5'd3, 1, 32'h0BAD_F00D);

        // Randomized back-to-back mix of ALU ops, loads, stores and read+write.
        for (int n = 0; n < 30; n++) begin
            int kind;
            kind = $urandom_range(0, 3);
            if (kind == 0)
                doAluOp($urandom, $urandom, $urandom, $urandom, $urandom);
            else
                doMemOp(kind != 2, kind != 1, $urandom, $urandom, $urandom, $urandom, $urandom,
                        $urandom_range(0, 3), $urandom);
        end

`ifdef MEM_ACCESS_TIMEOUT_EN
        // Ack on the last allowed cycle wins over the timeout.
        doMemOp(1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0400, 32'h0, 5'd4, 3, 32'h1357_9BDF);
        checkOutput("ack_beats_timeout", timeout_o, 0);
        doTimeoutOp(32'h0000_0500, 5'd6);
`else
        // Without the timeout feature a long wait still completes normally.
        doMemOp(1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0400, 32'h0, 5'd4, 8, 32'h1357_9BDF);
        checkOutput("no_timeout_flag", timeout_o, 0);
`endif

        // Reset pulsed mid-access aborts the request; a later ack does nothing.
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_0600, 32'h0, 5'd8);
        @(negedge clk_i);
        @(negedge clk_i);
        #1;
        checkOutput("pre_reset_req", mem_req_o, 1);
        rst_i = 1'b1;
        #1;
        checkAllZero("mid_reset");
        @(negedge clk_i);
        rst_i = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        mem_ack_i   = 1'b1;
        mem_rdata_i = $urandom;
        #1;
        checkOutput("stray_ack_req", mem_req_o, 0);
        checkOutput("stray_ack_stall", stall_o, 0);
        @(negedge clk_i);
        mem_ack_i = 1'b0;
        checkAllZero("after_stray_ack");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_access_stage.md
MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, 64, ACCESS-state cycle limit before abort; legal 2..1023.
REQ-002 clk_i  in  1  sole clock; all state updates on rising edge.
REQ-003 rst_i  in  1  reset, asynchronous, active-high.
REQ-004 RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i  in  1 each  control bits from EX/MEM register.
REQ-005 ALUResult_i  in  32  ALU result / memory byte address; MUX2Result_i  in  32  store data; RdAddr_i  in  5  destination register.
REQ-006 mem_req_o  out  1  memory request; mem_we_o  out  1  write strobe; mem_addr_o  out  32; mem_wdata_o  out  32.
REQ-007 mem_ack_i  in  1  one-cycle completion pulse; mem_rdata_i  in  32  load data, valid when mem_ack_i=1.
REQ-008 stall_o  out  1  freeze PC, IF/ID, ID/EX, EX/MEM while high.
REQ-009 RegWrite_o, MemtoReg_o  out  1 each; ALUResult_o  out  32; ReadData_o  out  32; RdAddr_o  out  5  MEM/WB register outputs.
REQ-010 timeout_o  out  1  sticky access-abort flag.

Function
REQ-011 Two-state FSM: IDLE, ACCESS; memop = MemRead_i | MemWrite_i.
REQ-012 IDLE, memop=0: MEM/WB captures all inputs each edge, ReadData_o<=0; stall_o=0; latency 1 cycle.
REQ-013 IDLE, memop=1: stall_o=1 combinationally; at edge latch ctrl, address, store data, RdAddr; go ACCESS; MEM/WB loads bubble (RegWrite_o=0, MemtoReg_o=0).
REQ-014 MemRead_i and MemWrite_i both high: treated as read; mem_we_o=0.
REQ-015 ACCESS: mem_req_o=1; mem_addr_o, mem_wdata_o, mem_we_o driven from latch, stable until ack; zero in IDLE.
REQ-016 ACCESS, mem_ack_i=0: stall_o=1; MEM/WB loads bubble each edge.
REQ-017 ACCESS, mem_ack_i=1: stall_o=0 same cycle; at edge MEM/WB loads latched ctrl/address/RdAddr, ReadData_o<=mem_rdata_i (read) or 0 (write); go IDLE.
REQ-018 Minimum memory-op latency: 2 cycles (ack in first ACCESS cycle); back-to-back memory ops have no idle gap beyond REQ-013.
REQ-019 mem_ack_i in IDLE ignored; no state or output change.
REQ-020 Inputs sampled only in IDLE; input changes during ACCESS ignored.

Reset
REQ-021 rst_i high: immediately FSM=IDLE, mem_req_o=0, mem_we_o=0, all MEM/WB outputs 0, stall_o=0, timeout_o=0, timeout counter 0.
REQ-022 Reset during ACCESS aborts request without waiting for ack; later stray ack ignored per REQ-019.
REQ-023 First state update after rst_i deasserts occurs on next rising clk_i.

Configuration
REQ-024 Macro MEM_ACCESS_TIMEOUT_EN defined: 10-bit counter cleared on ACCESS entry, increments per ACCESS cycle without ack.
REQ-025 With macro, counter reaching TIMEOUT_CYCLES-1 with no ack: stall_o=0 that cycle; at edge go IDLE, timeout_o<=1 (sticky until reset), MEM/WB loads latched entry with RegWrite_o=0, ReadData_o=0.
REQ-026 With macro, ack and timeout in same cycle: ack wins, REQ-017 applies, timeout_o unchanged.
REQ-027 Macro undefined: no counter; ACCESS waits indefinitely; timeout_o tied 0.

Verification
REQ-028 ALU op RegWrite_i=1, ALUResult_i=0x0000_0010, RdAddr_i=5 -> next edge RegWrite_o=1, ALUResult_o=0x10, RdAddr_o=5, stall_o=0 throughout.
REQ-029 Load addr 0x100, RdAddr_i=7, ack on 3rd ACCESS cycle with rdata 0xDEAD_BEEF -> stall_o high 3 cycles, mem_addr_o=0x100, then ReadData_o=0xDEADBEEF, RdAddr_o=7, MemtoReg_o=1.
REQ-030 Store addr 0x200 data 0x1234_5678, ack in first ACCESS cycle -> mem_we_o=1, mem_wdata_o=0x12345678 one cycle, ReadData_o=0, RegWrite_o=0, total 2 cycles.
REQ-031 Load in flight, rst_i pulsed mid-ACCESS -> mem_req_o=0 and all outputs 0 before next edge; later ack pulse causes no change.
REQ-032 MEM_ACCESS_TIMEOUT_EN, TIMEOUT_CYCLES=4, no ack -> mem_req_o high exactly 4 cycles, timeout_o=1 thereafter, RegWrite_o=0; with ack on 4th cycle timeout_o stays 0.
